lza_pipe: RTL and testbench
===========================

Name: lza_pipe

Overview:
- Parametrised, pipelined leading-zero anticipator (LZA) for the PE accumulate/normalise path.
- Predicts the normalisation shift of A+B, or of A-B in subtract mode, from the operands alone, in parallel with the adder.
- Successor to the fixed 107-bit combinational LZA. Adds generic width, a subtract mode, two register stages, and valid/ready flow control with backpressure.

Parameters:
- WIDTH, 107, operand width in bits; minimum 3.
- CW, $clog2(WIDTH+1), width of the zero-count output (7 at default).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  1 = anticipate A-B (B one's-complemented before the predictor); 0 = A+B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- zero_cnt  output  CW  predicted leading-zero count.
- all_zero  output  1  predictor string is all zero; zero_cnt = WIDTH.

Behaviour:
- Interface: one clock, clk; reset asynchronous, active-low, rst_n.
- Reset values: out_valid=0, zero_cnt=0, all_zero=0, internal stage valids=0. in_ready=1 once reset is released.
- Operand conditioning: B' = in_sub ? ~in_b : in_b.
  - T = A^B'
  - G = A&B'
  - Z = ~A&~B'
- Predictor string f[WIDTH-1:0]:
  - f[W-1] = ~T[W-1] & T[W-2]
  - for 1<=i<=W-2: f[i] = T[i+1]&((G[i]&~Z[i-1])|(Z[i]&~G[i-1])) | ~T[i+1]&((Z[i]&~Z[i-1])|(G[i]&~G[i-1]))
  - f[0] = 0
- Stage 1 (S1): registers f and s1_valid on a handshake. Inputs are captured only when in_valid & in_ready.
- Stage 2 (S2): leading-zero count of the registered f, registered into zero_cnt/all_zero with out_valid.
  - Count = number of zeros above the most significant 1 of f.
  - Structure: binary halving. f is zero-padded on the LSB side to the next power of two, so padding never counts as a leading zero ahead of a real 1.
  - If f == 0: zero_cnt = WIDTH (unsigned, fits CW), all_zero = 1; otherwise all_zero = 0.
- Latency: 2 cycles from accepted input to out_valid with no stall. Throughput 1 beat/cycle while out_ready=1.
- Flow control:
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no combinational path from in_valid).
- Backpressure:
  - While out_valid & ~out_ready, zero_cnt/all_zero/out_valid hold stable.
  - S1 holds its beat; at most 2 beats are buffered.
  - in_ready drops only when both stages are full.
- Simultaneous events:
  - If S2 drains and S1 advances in the same cycle, no bubble is inserted.
  - If out_ready and in_valid are both high with both stages full, accept, advance and drain all occur in one cycle.
- Bubbles: out_valid is never asserted for a cycle without an accepted input. Data registers may update freely when the associated valid is 0.
- Reset mid-operation: all valids clear immediately and asynchronously. In-flight beats are discarded and nothing is replayed.
- Accuracy: the count may be one less than the true leading-zero count of the sum; downstream corrects. The bench checks against the f-string definition above, not the exact sum.

Test Plan:
- WIDTH=8, sub=0: A=8'h40, B=0 -> zero_cnt=0, all_zero=0, out_valid exactly 2 cycles after acceptance.
- WIDTH=8, sub=0: A=8'h10, B=0 -> zero_cnt=2; A=8'h80, B=0 -> zero_cnt=1.
- WIDTH=8, sub=0: A=0, B=0 -> zero_cnt=8, all_zero=1. Default WIDTH: A=B=0 -> zero_cnt=107, all_zero=1.
- WIDTH=8, sub=1: A=8'h10, B=8'hFF (B'=0) -> zero_cnt=2, matches the sub=0 case A=8'h10, B=0.
- Streaming: 4 back-to-back beats, out_ready=0 for 3 cycles after the first result.
  - in_ready must fall after the 2nd beat is held in S1.
  - Outputs are held stable while stalled.
  - Results emerge in order with no loss or duplication once out_ready=1.
- Reset: assert rst_n=0 with both stages full -> out_valid=0 and zero_cnt=0 asynchronously. After release, in_ready=1 and no stale beat appears.
- Randomised: default WIDTH, random A/B/sub and random out_ready, checked against a reference model of f and the count.

Source files
------------

// File: rtl/lza_pipe.sv
// lza_pipe -- pipelined leading-zero anticipator.
//
// Predicts the normalisation shift of A+B (or A-B when in_sub=1) from the
// operands alone, so it can run alongside the adder. Two register stages:
//   S1 registers the predictor string f.
//   S2 registers the leading-zero count of f.
// Both stages use valid/ready flow control with full-rate backpressure. The
// predicted count may be one less than the true leading-zero count of the
// sum; the consumer corrects for that.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat this cycle
//   in_a       operand A            [WIDTH-1:0]
//   in_b       operand B            [WIDTH-1:0]
//   in_sub     1: anticipate A-B, 0: anticipate A+B
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   zero_cnt   predicted leading-zero count [CW-1:0]
//   all_zero   predictor string is all zero (zero_cnt = WIDTH)
module lza_pipe #(
  parameter int WIDTH = 107,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    zero_cnt,
  output logic             all_zero
);

  // Halving tree depth and the power-of-two width f is padded to.
  localparam int LW = $clog2(WIDTH);
  localparam int PW = 1 << LW;

  // ---------------------------------------------------------------------
  // Operand conditioning and predictor string
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_t;
  // G and Z are never used at the MSB, so they stop one bit short.
  logic [WIDTH-2:0] w_g;
  logic [WIDTH-2:0] w_z;
  logic [WIDTH-1:0] w_f;

  assign w_b = in_sub ? ~in_b : in_b;
  assign w_t = in_a ^ w_b;
  assign w_g = in_a[WIDTH-2:0] & w_b[WIDTH-2:0];
  assign w_z = ~in_a[WIDTH-2:0] & ~w_b[WIDTH-2:0];

  assign w_f[WIDTH-1] = ~w_t[WIDTH-1] & w_t[WIDTH-2];
  assign w_f[0]       = 1'b0;

  generate
    for (genvar gi = 1; gi <= WIDTH - 2; gi++) begin : g_f
      assign w_f[gi] = (w_t[gi+1] & ((w_g[gi] & ~w_z[gi-1]) | (w_z[gi] & ~w_g[gi-1])))
                     | (~w_t[gi+1] & ((w_z[gi] & ~w_z[gi-1]) | (w_g[gi] & ~w_g[gi-1])));
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------
  logic w_s1_adv;
  logic w_s2_adv;
  logic r_s1_valid;
  logic r_out_valid;

  assign w_s2_adv = ~r_out_valid | out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;

  // ---------------------------------------------------------------------
  // Stage 1: register f
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] r_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_f        <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_f <= w_f;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Leading-zero count of r_f by binary halving
  // ---------------------------------------------------------------------
  // Padding sits below the LSB, so it can only be reached when every real
  // bit is zero; that case is reported through all_zero instead.
  logic [PW-1:0] w_pad;
  logic [LW-1:0] w_cnt;
  logic          w_all_zero;
  logic [CW-1:0] w_zero_cnt;

  generate
    if (PW > WIDTH) begin : g_pad
      assign w_pad = {r_f, {(PW - WIDTH){1'b0}}};
    end else begin : g_nopad
      assign w_pad = r_f;
    end
  endgenerate

  // Each level asks whether the upper half of the current window is empty.
  // That answer is one count bit (MSB first). The level then keeps the half
  // that contains the leading one.
  generate
    for (genvar gi = 0; gi < LW; gi++) begin : g_lz
      localparam int HW = PW >> (gi + 1);
      logic [2*HW-1:0] w_v;
      logic [HW-1:0]   w_nxt;
      if (gi == 0) begin : g_first
        assign w_v = w_pad;
      end else begin : g_chain
        assign w_v = g_lz[gi-1].w_nxt;
      end
      assign w_cnt[LW-1-gi] = ~|w_v[2*HW-1:HW];
      assign w_nxt = w_cnt[LW-1-gi] ? w_v[HW-1:0] : w_v[2*HW-1:HW];
    end
  endgenerate

  // The final surviving bit is the leading one when f is non-zero.
  assign w_all_zero = ~g_lz[LW-1].w_nxt[0];
  assign w_zero_cnt = w_all_zero ? CW'(WIDTH) : CW'(w_cnt);

  // ---------------------------------------------------------------------
  // Stage 2: register count
  // ---------------------------------------------------------------------
  logic [CW-1:0] r_zero_cnt;
  logic          r_all_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_zero_cnt  <= '0;
      r_all_zero  <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_zero_cnt <= w_zero_cnt;
        r_all_zero <= w_all_zero;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign zero_cnt  = r_zero_cnt;
  assign all_zero  = r_all_zero;

endmodule

// File: tb/tb_lza_pipe.sv
// tb_lza_pipe -- self-checking bench for lza_pipe.
// u8 (WIDTH=8) takes the directed steps. u107 (default WIDTH) takes the
// all-zero boundary and the random traffic. Expected results are queued
// when a beat is accepted and compared when the result is consumed.
module tb_lza_pipe;

  typedef struct packed {
    logic       az;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  // WIDTH=8 instance
  logic [7:0] a8, b8;
  logic       sub8, v8, ir8, ov8, or8, az8;
  logic [3:0] zc8;

  // default-width instance
  logic [106:0] a1, b1;
  logic         sub1, v1, ir1, ov1, or1, az1;
  logic [6:0]   zc1;

  exp_t q8[$];
  exp_t q1[$];

  int n_vec  = 0;
  int n_fail = 0;

  lza_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8), .in_sub(sub8),
    .out_valid(ov8), .out_ready(or8), .zero_cnt(zc8), .all_zero(az8)
  );

  lza_pipe u107 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(ir1), .in_a(a1), .in_b(b1), .in_sub(sub1),
    .out_valid(ov1), .out_ready(or1), .zero_cnt(zc1), .all_zero(az1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model, written directly from the f-string definition.
  function automatic exp_t lza_ref(input logic [106:0] a, input logic [106:0] b,
                                   input logic sub, input int w);
    logic [106:0] bp, t, g, z, f;
    exp_t r;
    int   cnt;
    bit   found;
    bp = sub ? ~b : b;
    t  = a ^ bp;
    g  = a & bp;
    z  = ~a & ~bp;
    f  = '0;
    f[w-1] = ~t[w-1] & t[w-2];
    for (int i = 1; i <= w - 2; i++)
      f[i] = (t[i+1] & ((g[i] & ~z[i-1]) | (z[i] & ~g[i-1])))
           | (~t[i+1] & ((z[i] & ~z[i-1]) | (g[i] & ~g[i-1])));
    cnt = w;
    found = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      if (!found && f[i]) begin
        cnt = w - 1 - i;
        found = 1'b1;
      end
    end
    r.cnt = 8'(cnt);
    r.az  = !found;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each consumed result against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov8 && or8) begin
      n_vec++;
      assert (q8.size() != 0) else begin
        n_fail++;
        $error("FAIL u8_unexpected: observed out_valid=1 cnt=%0d expected no pending beat", zc8);
      end
      if (q8.size() != 0) begin
        e = q8.pop_front();
        n_vec++;
        assert ({az8, 8'(zc8)} === {e.az, e.cnt}) else begin
          n_fail++;
          $error("FAIL u8_result: observed cnt=%0d az=%0b expected cnt=%0d az=%0b",
                 zc8, az8, e.cnt, e.az);
        end
      end
    end
    if (rst_n && ov1 && or1) begin
      n_vec++;
      assert (q1.size() != 0) else begin
        n_fail++;
        $error("FAIL u107_unexpected: observed out_valid=1 cnt=%0d expected no pending beat", zc1);
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        n_vec++;
        assert ({az1, 8'(zc1)} === {e.az, e.cnt}) else begin
          n_fail++;
          $error("FAIL u107_result: observed cnt=%0d az=%0b expected cnt=%0d az=%0b",
                 zc1, az1, e.cnt, e.az);
        end
      end
    end
  end

  // Present one beat to u8, wait (bounded) for acceptance, queue its expectation.
  task automatic put8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input int ec, input logic eaz);
    int n;
    n = 0;
    a8 = a; b8 = b; sub8 = s; v8 = 1'b1;
    @(negedge clk);
    while (!ir8 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("put8_accept", 32'(ir8), 32'd1);
    if (ir8) q8.push_back({eaz, 8'(ec)});
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  task automatic put107(input logic [106:0] a, input logic [106:0] b, input logic s,
                        input int ec, input logic eaz);
    int n;
    n = 0;
    a1 = a; b1 = b; sub1 = s; v1 = 1'b1;
    @(negedge clk);
    while (!ir1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("put107_accept", 32'(ir1), 32'd1);
    if (ir1) q1.push_back({eaz, 8'(ec)});
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]   sbeat [4];
    logic [3:0]   scnt  [4];
    logic [127:0] r, m;
    exp_t         e;
    int           k;
    int           nacc;

    rst_n = 1'b0;
    a8 = '0; b8 = '0; sub8 = 1'b0; v8 = 1'b0; or8 = 1'b1;
    a1 = '0; b1 = '0; sub1 = 1'b0; v1 = 1'b0; or1 = 1'b1;

    // Reset state
    #2;
    chk("rst_ov8", 32'(ov8), 32'd0);
    chk("rst_zc8", 32'(zc8), 32'd0);
    chk("rst_az8", 32'(az8), 32'd0);
    chk("rst_ov107", 32'(ov1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_inrdy", 32'(ir8), 32'd1);
    @(posedge clk); #1;

    // Latency: result appears exactly two cycles after acceptance
    put8(8'h40, 8'h00, 1'b0, 0, 1'b0);
    chk("lat_e0_ov", 32'(ov8), 32'd0);
    @(posedge clk); #1;
    chk("lat_e1_ov", 32'(ov8), 32'd1);
    chk("lat_cnt", 32'(zc8), 32'd0);
    chk("lat_az", 32'(az8), 32'd0);

    // Directed patterns
    put8(8'h10, 8'h00, 1'b0, 2, 1'b0);
    put8(8'h80, 8'h00, 1'b0, 1, 1'b0);
    put8(8'h00, 8'h00, 1'b0, 8, 1'b1);
    put8(8'h10, 8'hFF, 1'b1, 2, 1'b0);
    put8(8'h08, 8'h00, 1'b0, 3, 1'b0);
    idle(4);
    chk("dir_drain", 32'(q8.size()), 32'd0);

    // Default width, all-zero boundary
    put107('0, '0, 1'b0, 107, 1'b1);
    idle(4);
    chk("zero107_drain", 32'(q1.size()), 32'd0);

    // Streaming with a 3-cycle stall after the first result
    sbeat[0] = 8'h40; scnt[0] = 4'd0;
    sbeat[1] = 8'h80; scnt[1] = 4'd1;
    sbeat[2] = 8'h10; scnt[2] = 4'd2;
    sbeat[3] = 8'h08; scnt[3] = 4'd3;
    k = 0;
    for (int cyc = 0; cyc < 30 && (k < 4 || q8.size() > 0); cyc++) begin
      or8 = !(cyc >= 2 && cyc <= 4);
      if (k < 4) begin
        a8 = sbeat[k]; b8 = 8'h00; sub8 = 1'b0; v8 = 1'b1;
      end else begin
        v8 = 1'b0;
      end
      @(negedge clk);
      if (cyc >= 2 && cyc <= 4) begin
        chk("stall_inrdy", 32'(ir8), 32'd0);
        chk("stall_ov", 32'(ov8), 32'd1);
        chk("stall_cnt", 32'(zc8), 32'd0);
      end
      if (v8 && ir8) begin
        q8.push_back({1'b0, 8'(scnt[k])});
        k++;
      end
      @(posedge clk); #1;
    end
    v8 = 1'b0; or8 = 1'b1;
    idle(4);
    chk("stream_beats", 32'(k), 32'd4);
    chk("stream_drain", 32'(q8.size()), 32'd0);

    // Reset with both stages full
    or8 = 1'b0;
    put8(8'h40, 8'h00, 1'b0, 0, 1'b0);
    put8(8'h80, 8'h00, 1'b0, 1, 1'b0);
    chk("full_ov", 32'(ov8), 32'd1);
    chk("full_inrdy", 32'(ir8), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ov", 32'(ov8), 32'd0);
    chk("async_cnt", 32'(zc8), 32'd0);
    q8.delete();
    q1.delete();
    or8 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_inrdy", 32'(ir8), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rel_nostale", 32'(ov8), 32'd0);
    end
    @(posedge clk); #1;

    // Random traffic on the default width
    nacc = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      or1 = ($urandom_range(0, 3) != 0);
      v1  = ($urandom_range(0, 3) != 0);
      r   = {$urandom(), $urandom(), $urandom(), $urandom()};
      m   = {$urandom(), $urandom(), $urandom(), $urandom()};
      m   = m >> $urandom_range(0, 127);
      a1  = r[106:0];
      case ($urandom_range(0, 3))
        0: begin sub1 = $urandom_range(0, 1) != 0; b1 = {r[52:0], r[127:74]}; end
        1: begin sub1 = 1'b1; b1 = a1 ^ m[106:0]; end
        2: begin sub1 = 1'b0; b1 = ~a1 ^ m[106:0]; end
        default: begin sub1 = $urandom_range(0, 1) != 0; a1 = m[106:0]; b1 = r[106:0] >> $urandom_range(0, 106); end
      endcase
      @(negedge clk);
      if (v1 && ir1) begin
        e = lza_ref(a1, b1, sub1, 107);
        q1.push_back(e);
        nacc++;
      end
      @(posedge clk); #1;
    end
    v1 = 1'b0; or1 = 1'b1;
    for (int i = 0; i < 20 && q1.size() > 0; i++) @(posedge clk);
    #1;
    chk("rand_drain", 32'(q1.size()), 32'd0);
    chk("rand_accepted", 32'(nacc > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
